mca_lut_param: RTL and testbench

MCA_LUT_PARAM -- requirements
Module: mca_lut_param

---
 rtl/mca_lut_param.sv | 136 +++++++++++++
 tb/tb_mca_lut_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mca_lut_param.sv
// Multi-term LUT accumulator: sums one signed LUT entry per term, one term per enabled cycle.
// Define MCA_LUT_PARAM_SATURATE_EN to clamp res to the signed WIDTH_RES range instead of wrapping.
module mca_lut_param #(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_ADDITIONS     = 16,
    parameter int LUT_BITS          = 4,
    parameter int WIDTH_RES         = 32
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      start,
    input  logic                                                      enable,
    input  logic [NUM_ADDITIONS*LUT_BITS-1:0]                         S_values,
    input  logic [NUM_ADDITIONS*(2**LUT_BITS)*WIDTH_COEFFICIENT-1:0]  lut,
    output logic                                                      busy,
    output logic                                                      res_valid,
    output logic signed [WIDTH_RES-1:0]                               res
);

    localparam int ENTRIES = 2**LUT_BITS;
    localparam int ROW_W   = ENTRIES*WIDTH_COEFFICIENT;
    localparam int CNT_W   = $clog2(NUM_ADDITIONS);
    localparam int ACC_W   = WIDTH_RES + CNT_W;
    localparam int SNAP_W  = NUM_ADDITIONS*LUT_BITS;
    localparam int EXT_W   = ACC_W - WIDTH_COEFFICIENT;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_ADDITIONS-1);

    typedef enum logic {
        IDLE   = 1'b0,
        ADDING = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q,   cnt_d;
    logic signed [ACC_W-1:0]     acc_q,   acc_d;
    logic [SNAP_W-1:0]           snap_q,  snap_d;
    logic signed [WIDTH_RES-1:0] res_q,   res_d;
    logic                        valid_q, valid_d;

    logic [ROW_W-1:0]                    row;
    logic [LUT_BITS-1:0]                 term_sel;
    logic signed [WIDTH_COEFFICIENT-1:0] term;
    logic signed [ACC_W-1:0]             sum;
    logic signed [WIDTH_RES-1:0]         final_res;

    // Pick the row of the current term, then the entry addressed by its snapshotted control bits.
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        row      = '0;
        term_sel = '0;
        term     = '0;
        for (int k = 0; k < NUM_ADDITIONS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                row      = lut[k*ROW_W +: ROW_W];
                term_sel = snap_q[k*LUT_BITS +: LUT_BITS];
            end
        end
        for (int a = 0; a < ENTRIES; a++) begin
            if (term_sel == LUT_BITS'(a)) begin
                term = row[a*WIDTH_COEFFICIENT +: WIDTH_COEFFICIENT];
            end
        end
    end

    assign sum = acc_q + {{EXT_W{term[WIDTH_COEFFICIENT-1]}}, term};

`ifdef MCA_LUT_PARAM_SATURATE_EN
    // The sum fits iff every bit above the result's sign bit matches it.
    always_comb begin
        final_res = sum[WIDTH_RES-1:0];
        if (!((&sum[ACC_W-1:WIDTH_RES-1]) || !(|sum[ACC_W-1:WIDTH_RES-1]))) begin
            final_res = sum[ACC_W-1] ? {1'b1, {(WIDTH_RES-1){1'b0}}}
                                     : {1'b0, {(WIDTH_RES-1){1'b1}}};
        end
    end
`else
    assign final_res = sum[WIDTH_RES-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        res_d   = res_q;
        valid_d = valid_q;
        if (enable) begin
            valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ADDING;
                        cnt_d   = '0;
                        acc_d   = '0;
                        snap_d  = S_values;
                    end
                end
                ADDING: begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_TERM) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        res_d   = final_res;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            snap_q  <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            snap_q  <= snap_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == ADDING);
    assign res_valid = valid_q;
    assign res       = res_q;

endmodule

// File: tb/tb_mca_lut_param.sv
// Directed bench for mca_lut_param with a transaction-level model checked every cycle.
// Honours MCA_LUT_PARAM_SATURATE_EN for the expected result of the narrow-width instance.
module tb_mca_lut_param;

    localparam int N  = 16;
    localparam int LB = 4;
    localparam int E  = 16;
    localparam int WC = 32;
    localparam int WR = 32;
    localparam longint MAXV = (longint'(1) << (WR-1)) - 1;
    localparam longint MINV = -(longint'(1) << (WR-1));

    logic clk = 1'b0;
    logic rst, start, enable, start8;
    logic [N*LB-1:0]   s_values;
    logic [N*E*WC-1:0] lut;
    logic [N*E*8-1:0]  lut8;
    logic busy, res_valid, busy8, valid8;
    logic signed [WR-1:0] res;
    logic signed [7:0]    res8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mca_lut_param dut (
        .clk(clk), .rst(rst), .start(start), .enable(enable),
        .S_values(s_values), .lut(lut),
        .busy(busy), .res_valid(res_valid), .res(res)
    );

    mca_lut_param #(.WIDTH_COEFFICIENT(8), .WIDTH_RES(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .enable(enable),
        .S_values(s_values), .lut(lut8),
        .busy(busy8), .res_valid(valid8), .res(res8)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(actual), $signed(expected), $time);
        end
    endtask

    // Model: a request is a full dot-product computed at acceptance; the answer appears N enabled edges later.
    bit m_busy = 1'b0;
    bit m_valid = 1'b0;
    int m_left = 0;
    longint m_sum = 0;
    logic signed [WR-1:0] m_res = '0;

    function automatic longint lut_sum(input logic [N*LB-1:0] s, input logic [N*E*WC-1:0] l);
        longint acc;
        int a;
        logic signed [WC-1:0] e;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            a   = int'(s[k*LB +: LB]);
            e   = l[(k*E+a)*WC +: WC];
            acc = acc + longint'(e);
        end
        return acc;
    endfunction

    function automatic logic signed [WR-1:0] fit(input longint v);
`ifdef MCA_LUT_PARAM_SATURATE_EN
        if (v > MAXV) return WR'(MAXV);
        if (v < MINV) return WR'(MINV);
`endif
        return WR'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_left = 0; m_res = '0;
        end else if (enable) begin
            m_valid = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                    m_res   = fit(m_sum);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = N;
                m_sum  = lut_sum(s_values, lut);
            end
        end
        #1;
        check("cyc_busy", 64'(busy), 64'(m_busy));
        check("cyc_res_valid", 64'(res_valid), 64'(m_valid));
        check("cyc_res", 64'(res), 64'(m_res));
    end

    task automatic set_lut_k_plus1();
        lut = '0;
        for (int k = 0; k < N; k++) lut[(k*E)*WC +: WC] = WC'(k+1);
    endtask

    task automatic set_lut_a();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < E; a++) lut[(k*E+a)*WC +: WC] = WC'(a);
    endtask

    task automatic pulse_start(input logic [N*LB-1:0] s);
        @(negedge clk);
        start = 1'b1; s_values = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the acceptance edge until res_valid; optionally toggles enable each cycle.
    task automatic wait_valid(input bit toggle, output int cycles);
        cycles = 0;
        if (toggle) enable = 1'b0;
        forever begin
            @(posedge clk); #2;
            cycles++;
            if (res_valid) break;
            if (cycles > 200) begin
                check("timeout_res_valid", 64'(res_valid), 64'(1));
                break;
            end
            if (toggle) begin
                @(negedge clk);
                enable = ~enable;
            end
        end
        if (toggle) enable = 1'b1;
    endtask

    initial begin
        int cyc;
        int nvalid;
        logic signed [WR-1:0] last_res;
        logic [N*LB-1:0] s3;
        for (int k = 0; k < N; k++) s3[k*LB +: LB] = 4'h3;

        rst = 1'b1; enable = 1'b0; start = 1'b0; start8 = 1'b0;
        s_values = '0; lut = '0; lut8 = '0;
        @(posedge clk); #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_res_valid", 64'(res_valid), 64'(0));
        check("reset_res", 64'(res), 64'(0));
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;

        // Scenario 1: sum of k+1 over 16 terms.
        set_lut_k_plus1();
        pulse_start('0);
        check("s1_busy_after_start", 64'(busy), 64'(1));
        wait_valid(1'b0, cyc);
        check("s1_latency", 64'(cyc), 64'(16));
        check("s1_res", 64'(res), 64'(136));

        // Scenario 2: all control bits set, then back-to-back restart with zero controls.
        set_lut_a();
        pulse_start({N*LB{1'b1}});
        wait_valid(1'b0, cyc);
        check("s2_res", 64'(res), 64'(240));
        pulse_start('0);
        wait_valid(1'b0, cyc);
        check("s2_restart_latency", 64'(cyc + 1), 64'(17));
        check("s2_res2", 64'(res), 64'(0));

        // Scenario 3: enable toggling halves the throughput but not the result.
        set_lut_k_plus1();
        pulse_start('0);
        wait_valid(1'b1, cyc);
        check("s3_latency", 64'(cyc), 64'(32));
        check("s3_res", 64'(res), 64'(136));
        repeat (3) @(negedge clk);

        // Scenario 4: reset at counter 7 aborts, then a full run recovers.
        pulse_start('0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s4_busy", 64'(busy), 64'(0));
        check("s4_res", 64'(res), 64'(0));
        check("s4_res_valid", 64'(res_valid), 64'(0));
        repeat (20) @(negedge clk);
        check("s4_no_late_valid", 64'(res_valid), 64'(0));
        pulse_start('0);
        wait_valid(1'b0, cyc);
        check("s4_latency", 64'(cyc), 64'(16));
        check("s4_res_after", 64'(res), 64'(136));

        // Scenario 5: start held and controls changed mid-run.
        set_lut_a();
        @(negedge clk);
        start = 1'b1; s_values = s3;
        nvalid = 0; last_res = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (res_valid) begin
                nvalid++;
                last_res = res;
                start = 1'b0;
            end
            if (i == 5) s_values = {N*LB{1'b1}};
        end
        start = 1'b0;
        check("s5_result_count", 64'(nvalid), 64'(1));
        check("s5_res", 64'(last_res), 64'(48));
        check("s5_idle", 64'(busy), 64'(0));

        // Scenario 6: narrow instance, 16 x 100 overflows 8 bits.
        for (int j = 0; j < N*E; j++) lut8[j*8 +: 8] = 8'd100;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!valid8 && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("s6_valid", 64'(valid8), 64'(1));
        check("s6_latency", 64'(cyc), 64'(16));
`ifdef MCA_LUT_PARAM_SATURATE_EN
        check("s6_res_sat", 64'(res8), 64'(127));
`else
        check("s6_res_wrap", 64'(res8), 64'(64));
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
